// File: rtl/blob_bbox_tracker.sv
// blob_bbox_tracker: streaming connected-component labeller emitting per-blob bounding boxes; define BLOB_AREA_EN to add the bbox_area pixel count
module blob_bbox_tracker #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int MAX_OBJ = 15,
  parameter int CW = 11
) (
  input  logic app_clk,
  input  logic app_rst,
  input  logic pix_valid,
  input  logic pix_fg,
  input  logic [CW-1:0] hpos,
  input  logic [CW-1:0] vpos,
  output logic bbox_valid,
  input  logic bbox_ready,
  output logic [$clog2(MAX_OBJ+1)-1:0] bbox_id,
  output logic [CW-1:0] bbox_xmin,
  output logic [CW-1:0] bbox_xmax,
  output logic [CW-1:0] bbox_ymin,
  output logic [CW-1:0] bbox_ymax,
  output logic [$clog2(MAX_OBJ+1)-1:0] blob_count,
  output logic obj_overflow,
`ifdef BLOB_AREA_EN
  output logic [$clog2(H_RES*V_RES+1)-1:0] bbox_area,
`endif
  output logic frame_done
);
  localparam int LB = $clog2(MAX_OBJ+1);
  localparam int NL = 1 << LB;
  localparam int AW = $clog2(H_RES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] READOUT = 2'd2;
  logic [1:0] state_q, state_d;
  logic [LB:0] nf_q, nf_d;
  logic ovf_q, ovf_d;
  logic [LB-1:0] alias_q [NL];
  logic [LB-1:0] alias_d [NL];
  logic [NL-1:0] dead_q, dead_d, pend_q, pend_d;
  logic [CW-1:0] xlo_q [NL];
  logic [CW-1:0] xlo_d [NL];
  logic [CW-1:0] xhi_q [NL];
  logic [CW-1:0] xhi_d [NL];
  logic [CW-1:0] ylo_q [NL];
  logic [CW-1:0] ylo_d [NL];
  logic [CW-1:0] yhi_q [NL];
  logic [CW-1:0] yhi_d [NL];
  logic [LB-1:0] left_q, left_d, ul_q, ul_d;
  logic [LB-1:0] lb_q [H_RES];
  logic [LB-1:0] cnt_q, cnt_d;
  logic bv_q, bv_d, done_q, done_d;
  logic [LB-1:0] id_q, id_d;
  logic [CW-1:0] oxlo_q, oxlo_d, oxhi_q, oxhi_d, oylo_q, oylo_d, oyhi_q, oyhi_d;
  logic first, acc, last;
  logic [AW-1:0] hx, hx1;
  logic [LB-1:0] up, m, lbl, ridx, cnt;
  logic [LB-1:0] t [4];
  logic [CW-1:0] ux_lo, ux_hi, uy_lo, uy_hi;
  logic [NL-1:0] live;
`ifdef BLOB_AREA_EN
  localparam int AR = $clog2(H_RES*V_RES+1);
  logic [AR-1:0] area_q [NL];
  logic [AR-1:0] area_d [NL];
  logic [AR-1:0] oarea_q, oarea_d, asum;
  logic dup;
`endif
  always_comb begin
    hx = hpos[AW-1:0];
    hx1 = (hx == AW'(H_RES-1)) ? '0 : hx + AW'(1);
    first = state_q == IDLE && pix_valid && hpos == '0 && vpos == '0;
    acc = pix_valid && hpos < CW'(H_RES) && vpos < CW'(V_RES) && (state_q == SCAN || first);
    last = hpos == CW'(H_RES-1) && vpos == CW'(V_RES-1);
    up = vpos != '0 ? lb_q[hx] : '0;
    t[0] = hpos != '0 ? alias_q[left_q] : '0;
    t[1] = hpos != '0 ? alias_q[ul_q] : '0;
    t[2] = alias_q[up];
    t[3] = (vpos != '0 && hx != AW'(H_RES-1)) ? alias_q[lb_q[hx1]] : '0;
  end
  always_comb begin
    state_d = state_q;
    nf_d = nf_q;
    ovf_d = ovf_q;
    alias_d = alias_q;
    dead_d = dead_q;
    pend_d = pend_q;
    xlo_d = xlo_q;
    xhi_d = xhi_q;
    ylo_d = ylo_q;
    yhi_d = yhi_q;
    left_d = left_q;
    ul_d = ul_q;
    cnt_d = cnt_q;
    bv_d = bv_q;
    done_d = 1'b0;
    id_d = id_q;
    oxlo_d = oxlo_q;
    oxhi_d = oxhi_q;
    oylo_d = oylo_q;
    oyhi_d = oyhi_q;
    m = '0;
    lbl = '0;
    ridx = '0;
    cnt = '0;
    live = '0;
    ux_lo = hpos;
    ux_hi = hpos;
    uy_lo = vpos;
    uy_hi = vpos;
`ifdef BLOB_AREA_EN
    area_d = area_q;
    oarea_d = oarea_q;
    asum = AR'(1);
    dup = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (t[k] != '0 && (m == '0 || t[k] < m)) m = t[k];
      if (t[k] != '0) begin
        ux_lo = xlo_q[t[k]] < ux_lo ? xlo_q[t[k]] : ux_lo;
        ux_hi = xhi_q[t[k]] > ux_hi ? xhi_q[t[k]] : ux_hi;
        uy_lo = ylo_q[t[k]] < uy_lo ? ylo_q[t[k]] : uy_lo;
        uy_hi = yhi_q[t[k]] > uy_hi ? yhi_q[t[k]] : uy_hi;
      end
`ifdef BLOB_AREA_EN
      dup = 1'b0;
      for (int j = 0; j < k; j++) if (t[j] == t[k]) dup = 1'b1;
      if (t[k] != '0 && !dup) asum = asum + area_q[t[k]];
`endif
    end
    if (first) begin
      nf_d = (LB+1)'(1);
      ovf_d = 1'b0;
      dead_d = '0;
      for (int i = 0; i < NL; i++) alias_d[i] = LB'(i);
    end
    if (acc) begin
      if (pix_fg && m == '0 && nf_d <= (LB+1)'(MAX_OBJ)) begin
        lbl = nf_d[LB-1:0];
        nf_d = nf_d + (LB+1)'(1);
        alias_d[lbl] = lbl;
        dead_d[lbl] = 1'b0;
        xlo_d[lbl] = hpos;
        xhi_d[lbl] = hpos;
        ylo_d[lbl] = vpos;
        yhi_d[lbl] = vpos;
`ifdef BLOB_AREA_EN
        area_d[lbl] = AR'(1);
`endif
      end else if (pix_fg && m == '0) begin
        ovf_d = 1'b1;
      end else if (pix_fg) begin
        lbl = m;
        xlo_d[m] = ux_lo;
        xhi_d[m] = ux_hi;
        ylo_d[m] = uy_lo;
        yhi_d[m] = uy_hi;
`ifdef BLOB_AREA_EN
        area_d[m] = asum;
`endif
        for (int k = 0; k < 4; k++) begin
          if (t[k] != '0 && t[k] != m) begin
            dead_d[t[k]] = 1'b1;
            for (int i = 1; i < NL; i++) if (alias_q[i] == t[k]) alias_d[i] = m;
          end
        end
      end
      left_d = lbl;
      ul_d = up;
      if (last) begin
        for (int i = 1; i < NL; i++) live[i] = (LB+1)'(i) < nf_d && !dead_d[i];
        for (int i = 1; i < NL; i++) cnt = cnt + LB'(live[i]);
        pend_d = live;
        cnt_d = cnt;
        bv_d = 1'b0;
        state_d = live == '0 ? IDLE : READOUT;
        done_d = live == '0;
      end else if (first) begin
        state_d = SCAN;
      end
    end else if (state_q == READOUT && (!bv_q || bbox_ready)) begin
      for (int i = NL-1; i >= 1; i--) if (pend_q[i]) ridx = LB'(i);
      bv_d = pend_q != '0;
      done_d = pend_q == '0;
      state_d = pend_q == '0 ? IDLE : READOUT;
      if (pend_q != '0) begin
        pend_d[ridx] = 1'b0;
        id_d = ridx;
        oxlo_d = xlo_q[ridx];
        oxhi_d = xhi_q[ridx];
        oylo_d = ylo_q[ridx];
        oyhi_d = yhi_q[ridx];
`ifdef BLOB_AREA_EN
        oarea_d = area_q[ridx];
`endif
      end
    end
  end
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state_q <= IDLE;
      nf_q <= '0;
      ovf_q <= 1'b0;
      dead_q <= '0;
      pend_q <= '0;
      left_q <= '0;
      ul_q <= '0;
      cnt_q <= '0;
      bv_q <= 1'b0;
      done_q <= 1'b0;
      id_q <= '0;
      oxlo_q <= '0;
      oxhi_q <= '0;
      oylo_q <= '0;
      oyhi_q <= '0;
`ifdef BLOB_AREA_EN
      oarea_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      nf_q <= nf_d;
      ovf_q <= ovf_d;
      dead_q <= dead_d;
      pend_q <= pend_d;
      left_q <= left_d;
      ul_q <= ul_d;
      cnt_q <= cnt_d;
      bv_q <= bv_d;
      done_q <= done_d;
      id_q <= id_d;
      oxlo_q <= oxlo_d;
      oxhi_q <= oxhi_d;
      oylo_q <= oylo_d;
      oyhi_q <= oyhi_d;
`ifdef BLOB_AREA_EN
      oarea_q <= oarea_d;
`endif
    end
  end
  always_ff @(posedge app_clk) begin
    alias_q <= alias_d;
    xlo_q <= xlo_d;
    xhi_q <= xhi_d;
    ylo_q <= ylo_d;
    yhi_q <= yhi_d;
`ifdef BLOB_AREA_EN
    area_q <= area_d;
`endif
    if (acc) lb_q[hx] <= lbl;
  end
  assign bbox_valid = bv_q;
  assign bbox_id = id_q;
  assign bbox_xmin = oxlo_q;
  assign bbox_xmax = oxhi_q;
  assign bbox_ymin = oylo_q;
  assign bbox_ymax = oyhi_q;
  assign blob_count = cnt_q;
  assign obj_overflow = ovf_q;
  assign frame_done = done_q;
`ifdef BLOB_AREA_EN
  assign bbox_area = oarea_q;
`endif
endmodule

// File: tb/tb_blob_bbox_tracker.sv
// tb_blob_bbox_tracker: directed frames covering single blob, U merge, label overflow, mid-frame reset, back-pressure and an empty frame
module tb_blob_bbox_tracker;
  localparam int H = 112;
  localparam int V = 62;
  localparam int MO = 15;
  localparam int CW = 11;
  localparam int LB = 4;
  typedef struct {
    int id;
    int x0;
    int x1;
    int y0;
    int y1;
    int a;
  } rec_t;
  logic app_clk = 1'b0;
  logic app_rst = 1'b1;
  logic pix_valid = 1'b0;
  logic pix_fg = 1'b0;
  logic bbox_ready = 1'b1;
  logic [CW-1:0] hpos = '0;
  logic [CW-1:0] vpos = '0;
  logic bbox_valid, obj_overflow, frame_done;
  logic [LB-1:0] bbox_id, blob_count;
  logic [CW-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`ifdef BLOB_AREA_EN
  logic [$clog2(H*V+1)-1:0] bbox_area;
`endif
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int vcnt = 0;
  int d0 = 0;
  rec_t recs[$];
  blob_bbox_tracker #(.H_RES(H), .V_RES(V), .MAX_OBJ(MO), .CW(CW)) dut (
    .app_clk(app_clk),
    .app_rst(app_rst),
    .pix_valid(pix_valid),
    .pix_fg(pix_fg),
    .hpos(hpos),
    .vpos(vpos),
    .bbox_valid(bbox_valid),
    .bbox_ready(bbox_ready),
    .bbox_id(bbox_id),
    .bbox_xmin(bbox_xmin),
    .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin),
    .bbox_ymax(bbox_ymax),
    .blob_count(blob_count),
    .obj_overflow(obj_overflow),
`ifdef BLOB_AREA_EN
    .bbox_area(bbox_area),
`endif
    .frame_done(frame_done)
  );
  always #5 app_clk = ~app_clk;
  always @(negedge app_clk) begin
    rec_t r;
    if (!app_rst) begin
      if (frame_done) done_cnt++;
      if (bbox_valid) vcnt++;
      if (bbox_valid && bbox_ready) begin
        r.id = int'(bbox_id);
        r.x0 = int'(bbox_xmin);
        r.x1 = int'(bbox_xmax);
        r.y0 = int'(bbox_ymin);
        r.y1 = int'(bbox_ymax);
        r.a = 0;
`ifdef BLOB_AREA_EN
        r.a = int'(bbox_area);
`endif
        recs.push_back(r);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic fgf(input int mode, input int x, input int y);
    case (mode)
      1: return x >= 100 && x <= 109 && y >= 50 && y <= 59;
      2: return (y >= 5 && y <= 20 && ((x >= 10 && x <= 12) || (x >= 20 && x <= 22))) || (y >= 18 && y <= 20 && x >= 10 && x <= 22);
      3: return y == 10 && x % 4 == 2 && x <= 66;
      4: return (x >= 5 && x <= 8 && y >= 5 && y <= 8) || (x >= 30 && x <= 33 && y >= 40 && y <= 45);
      default: return 1'b0;
    endcase
  endfunction
  task automatic drive(input int mode, input int rows);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < H; x++) begin
        @(posedge app_clk);
        #1;
        pix_valid = 1'b1;
        hpos = CW'(x);
        vpos = CW'(y);
        pix_fg = fgf(mode, x, y);
      end
    end
    @(posedge app_clk);
    #1;
    pix_valid = 1'b0;
    pix_fg = 1'b0;
  endtask
  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 300) begin
      @(negedge app_clk);
      t++;
    end
    repeat (3) @(negedge app_clk);
    chk("frame_done_pulses", done_cnt - base, 1);
  endtask
  task automatic run(input int mode);
    recs.delete();
    vcnt = 0;
    d0 = done_cnt;
    drive(mode, V);
    wait_done(d0);
  endtask
  task automatic chk_rec(input string tag, input int i, input int id, input int x0, input int x1, input int y0, input int y1);
    if (recs.size() > i) begin
      chk({tag, "_id"}, recs[i].id, id);
      chk({tag, "_xmin"}, recs[i].x0, x0);
      chk({tag, "_xmax"}, recs[i].x1, x1);
      chk({tag, "_ymin"}, recs[i].y0, y0);
      chk({tag, "_ymax"}, recs[i].y1, y1);
    end
  endtask
  initial begin
    repeat (3) @(posedge app_clk);
    #1;
    app_rst = 1'b0;
    @(negedge app_clk);
    chk("rst_valid", bbox_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", blob_count, 0);
    chk("rst_ovf", obj_overflow, 0);
    chk("rst_xmin", bbox_xmin, 0);
    chk("rst_ymax", bbox_ymax, 0);
    run(1);
    chk("sq_records", recs.size(), 1);
    chk_rec("sq", 0, 1, 100, 109, 50, 59);
    chk("sq_count", blob_count, 1);
    chk("sq_ovf", obj_overflow, 0);
`ifdef BLOB_AREA_EN
    if (recs.size() > 0) chk("sq_area", recs[0].a, 100);
`endif
    run(2);
    chk("u_records", recs.size(), 1);
    chk_rec("u", 0, 1, 10, 22, 5, 20);
    chk("u_count", blob_count, 1);
`ifdef BLOB_AREA_EN
    if (recs.size() > 0) chk("u_area", recs[0].a, 117);
`endif
    run(3);
    chk("dots_records", recs.size(), MO);
    for (int i = 0; i < MO; i++) chk_rec("dot", i, i + 1, 4 * i + 2, 4 * i + 2, 10, 10);
    chk("dots_ovf", obj_overflow, 1);
    chk("dots_count", blob_count, MO);
    recs.delete();
    drive(4, 30);
    app_rst = 1'b1;
    repeat (2) @(posedge app_clk);
    #1;
    app_rst = 1'b0;
    repeat (4) @(negedge app_clk);
    chk("abort_valid", bbox_valid, 0);
    chk("abort_count", blob_count, 0);
    chk("abort_ovf", obj_overflow, 0);
    chk("abort_records", recs.size(), 0);
    run(1);
    chk("clean_records", recs.size(), 1);
    chk_rec("clean", 0, 1, 100, 109, 50, 59);
    chk("clean_count", blob_count, 1);
    bbox_ready = 1'b0;
    recs.delete();
    vcnt = 0;
    d0 = done_cnt;
    drive(4, V);
    for (int t = 0; t < 50 && !bbox_valid; t++) @(negedge app_clk);
    chk("stall_valid_up", bbox_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge app_clk);
      #1;
      pix_valid = 1'b1;
      hpos = '0;
      vpos = '0;
      pix_fg = 1'b1;
      @(negedge app_clk);
      chk("stall_valid", bbox_valid, 1);
      chk("stall_id", bbox_id, 1);
      chk("stall_xmax", bbox_xmax, 8);
      chk("stall_ymin", bbox_ymin, 5);
    end
    @(posedge app_clk);
    #1;
    pix_valid = 1'b0;
    pix_fg = 1'b0;
    bbox_ready = 1'b1;
    wait_done(d0);
    chk("stall_records", recs.size(), 2);
    chk_rec("stall0", 0, 1, 5, 8, 5, 8);
    chk_rec("stall1", 1, 2, 30, 33, 40, 45);
    chk("stall_count", blob_count, 2);
    run(0);
    chk("empty_records", recs.size(), 0);
    chk("empty_valid_cycles", vcnt, 0);
    chk("empty_count", blob_count, 0);
    chk("empty_ovf", obj_overflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
